// File: rtl/tone_sequencer.sv
// Square-wave melody player: run-time loaded note RAM, per-note length multiplier,
// and start/stop/loop sequencing with busy, done and write-reject status.
module tone_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int PERIOD_W = 18,
  parameter int DUR_W    = 25,
  parameter int NOTE_CYC = 5035000,
  parameter int GAP_CYC  = 535000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [PERIOD_W+1:0]   wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     last_idx,
  output logic                  speaker,
  output logic                  busy,
  output logic [ADDR_W-1:0]     note_idx,
  output logic                  done,
  output logic                  wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Last count of the note and first silent count, one pair per duration code.
  localparam logic [DUR_W-1:0] LAST_0 = DUR_W'(1 * NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] LAST_1 = DUR_W'(2 * NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] LAST_2 = DUR_W'(3 * NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] LAST_3 = DUR_W'(4 * NOTE_CYC - 1);
  localparam logic [DUR_W-1:0] GAP_0  = DUR_W'(1 * NOTE_CYC - GAP_CYC);
  localparam logic [DUR_W-1:0] GAP_1  = DUR_W'(2 * NOTE_CYC - GAP_CYC);
  localparam logic [DUR_W-1:0] GAP_2  = DUR_W'(3 * NOTE_CYC - GAP_CYC);
  localparam logic [DUR_W-1:0] GAP_3  = DUR_W'(4 * NOTE_CYC - GAP_CYC);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     note_idx_q, note_idx_d;
  logic [DUR_W-1:0]      dur_cnt_q, dur_cnt_d;
  logic [PERIOD_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                  speaker_q, speaker_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;

  logic [PERIOD_W+1:0]   mem [DEPTH];
  logic [PERIOD_W+1:0]   entry;
  logic [PERIOD_W-1:0]   period;
  logic [1:0]            dur_code;
  logic [DUR_W-1:0]      last_cnt;
  logic [DUR_W-1:0]      gap_cnt;
  logic [DUR_W-1:0]      dur_inc;
  logic                  playing;
  logic                  note_end;
  logic                  song_end;

  // RAM is only writable while idle, so the combinational read never races a write.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign entry    = mem[note_idx_q];
  assign period   = entry[PERIOD_W-1:0];
  assign dur_code = entry[PERIOD_W+1:PERIOD_W];

  always_comb begin
    last_cnt = LAST_0;
    gap_cnt  = GAP_0;
    case (dur_code)
      2'd0: begin last_cnt = LAST_0; gap_cnt = GAP_0; end
      2'd1: begin last_cnt = LAST_1; gap_cnt = GAP_1; end
      2'd2: begin last_cnt = LAST_2; gap_cnt = GAP_2; end
      default: begin last_cnt = LAST_3; gap_cnt = GAP_3; end
    endcase
  end

  assign playing  = (state_q == PLAY);
  assign dur_inc  = dur_cnt_q + DUR_W'(1);
  assign note_end = playing && (dur_cnt_q == last_cnt);
  assign song_end = note_end && (note_idx_q == last_idx) && !loop_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      note_idx_q <= '0;
      dur_cnt_q  <= '0;
      tone_cnt_q <= '0;
      speaker_q  <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      dur_cnt_q  <= dur_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      speaker_q  <= speaker_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Stop has priority over start so a collision leaves the player idle.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = PLAY;
    end else if (song_end) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    note_idx_d = note_idx_q;
    dur_cnt_d  = dur_cnt_q;
    tone_cnt_d = tone_cnt_q;
    speaker_d  = speaker_q;
    done_d     = 1'b0;
    wr_err_d   = wr_en && playing;
    if (stop) begin
      dur_cnt_d  = '0;
      tone_cnt_d = '0;
      speaker_d  = 1'b0;
    end else if (start) begin
      note_idx_d = '0;
      dur_cnt_d  = '0;
      tone_cnt_d = '0;
      speaker_d  = 1'b0;
    end else if (playing) begin
      if (note_end) begin
        dur_cnt_d  = '0;
        tone_cnt_d = '0;
        speaker_d  = 1'b0;
        if (note_idx_q != last_idx) begin
          note_idx_d = note_idx_q + ADDR_W'(1);
        end else if (loop_en) begin
          note_idx_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        dur_cnt_d = dur_inc;
        if (dur_inc == gap_cnt) begin
          tone_cnt_d = '0;
          speaker_d  = 1'b0;
        end else if ((dur_cnt_q < gap_cnt) && (period != '0)) begin
          if (tone_cnt_q == (period - PERIOD_W'(1))) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker_q;
          end else begin
            tone_cnt_d = tone_cnt_q + PERIOD_W'(1);
          end
        end
      end
    end else begin
      speaker_d = 1'b0;
    end
  end

  assign speaker  = speaker_q;
  assign busy     = playing;
  assign note_idx = note_idx_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed and random songs compared cycle by cycle
// against a closed-form model of the note waveform.
module tb_tone_sequencer;

  localparam int ADDR_W   = 2;
  localparam int PERIOD_W = 6;
  localparam int DUR_W    = 8;
  localparam int NOTE_CYC = 20;
  localparam int GAP_CYC  = 4;

  logic                clk;
  logic                rst_n;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PERIOD_W+1:0] wr_data;
  logic                start;
  logic                stop;
  logic                loop_en;
  logic [ADDR_W-1:0]   last_idx;
  logic                speaker;
  logic                busy;
  logic [ADDR_W-1:0]   note_idx;
  logic                done;
  logic                wr_err;

  int checks;
  int failures;
  int ramCode [4];
  int ramPer  [4];

  tone_sequencer #(
    .ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
    .NOTE_CYC(NOTE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .last_idx(last_idx),
    .speaker(speaker), .busy(busy), .note_idx(note_idx), .done(done), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int noteLen(input int idx);
    return (ramCode[idx] + 1) * NOTE_CYC;
  endfunction

  // Speaker is high during odd half-periods of the audible window, low otherwise.
  function automatic logic expSpk(input int idx, input int d);
    int p;
    int a;
    p = ramPer[idx];
    a = noteLen(idx) - GAP_CYC;
    if (p == 0 || d >= a) return 1'b0;
    return ((d / p) % 2) == 1;
  endfunction

  task automatic writeRam(input int addr, input int code, input int per);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = {2'(code), PERIOD_W'(per)};
    tick;
    wr_en = 1'b0;
    ramCode[addr] = code;
    ramPer[addr]  = per;
    chk("idle_write_no_err", 32'(wr_err), 0);
  endtask

  task automatic pulseStart;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic checkNote(input int idx, input int from, input int upto);
    for (int d = from; d < upto && d < noteLen(idx); d++) begin
      chk($sformatf("n%0d_d%0d_busy", idx, d), 32'(busy), 1);
      chk($sformatf("n%0d_d%0d_idx", idx, d), 32'(note_idx), 32'(idx));
      chk($sformatf("n%0d_d%0d_spk", idx, d), 32'(speaker), 32'(expSpk(idx, d)));
      chk($sformatf("n%0d_d%0d_done", idx, d), 32'(done), 0);
      tick;
    end
  endtask

  task automatic checkDone;
    chk("end_done", 32'(done), 1);
    chk("end_busy", 32'(busy), 0);
    chk("end_spk", 32'(speaker), 0);
    tick;
    chk("after_done", 32'(done), 0);
    chk("after_busy", 32'(busy), 0);
  endtask

  task automatic playSong(input int last);
    int idx;
    idx = 0;
    for (int n = 0; n < 8; n++) begin
      checkNote(idx, 0, noteLen(idx));
      if (idx == last) break;
      idx = (idx + 1) % 4;
    end
    checkDone;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    last_idx = '0;
    for (int i = 0; i < 4; i++) begin ramCode[i] = 0; ramPer[i] = 0; end

    #2 rst_n = 1'b0;
    tick;
    chk("rst_spk", 32'(speaker), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_err", 32'(wr_err), 0);
    rst_n = 1'b1;
    tick;

    $display("[TB] single short note");
    writeRam(0, 0, 3);
    last_idx = 2'd0;
    loop_en  = 1'b0;
    pulseStart;
    playSong(0);

    $display("[TB] long note followed by rest");
    writeRam(0, 3, 2);
    writeRam(1, 0, 0);
    last_idx = 2'd1;
    pulseStart;
    playSong(1);

    $display("[TB] looping and late loop clear");
    writeRam(0, 0, 3);
    writeRam(1, 0, 1);
    writeRam(2, 1, 5);
    writeRam(3, 0, 2);
    last_idx = 2'd2;
    loop_en  = 1'b1;
    pulseStart;
    for (int i = 0; i < 3; i++) checkNote(i, 0, noteLen(i));
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, noteLen(1));
    checkNote(2, 0, 10);
    loop_en = 1'b0;
    checkNote(2, 10, noteLen(2));
    checkDone;

    $display("[TB] last_idx below note_idx wraps around");
    last_idx = 2'd3;
    pulseStart;
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, noteLen(1));
    checkNote(2, 0, 10);
    last_idx = 2'd1;
    checkNote(2, 10, noteLen(2));
    checkNote(3, 0, noteLen(3));
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, noteLen(1));
    checkDone;

    $display("[TB] stop mid-note");
    last_idx = 2'd2;
    pulseStart;
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, 7);
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 0);
    chk("stop_spk", 32'(speaker), 0);
    chk("stop_done", 32'(done), 0);
    tick;
    chk("stop_no_late_done", 32'(done), 0);

    $display("[TB] start and stop together");
    start = 1'b1;
    stop  = 1'b1;
    tick;
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", 32'(busy), 0);
    tick;
    chk("startstop_busy2", 32'(busy), 0);

    $display("[TB] restart mid-song");
    pulseStart;
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, 5);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("restart_idx", 32'(note_idx), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_spk", 32'(speaker), 0);
    checkNote(0, 0, noteLen(0));
    checkNote(1, 0, noteLen(1));
    checkNote(2, 0, noteLen(2));
    checkDone;

    $display("[TB] write while playing is rejected");
    last_idx = 2'd0;
    pulseStart;
    checkNote(0, 0, 3);
    wr_en   = 1'b1;
    wr_addr = 2'd0;
    wr_data = {2'd2, 6'd1};
    checkNote(0, 3, 4);
    wr_en = 1'b0;
    chk("busy_wr_err", 32'(wr_err), 1);
    checkNote(0, 4, 5);
    chk("busy_wr_err_pulse", 32'(wr_err), 0);
    checkNote(0, 5, noteLen(0));
    checkDone;
    pulseStart;
    playSong(0);

    $display("[TB] random songs");
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 4; a++) begin
        writeRam(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
      end
      last_idx = ADDR_W'($urandom_range(0, 3));
      loop_en  = 1'b0;
      pulseStart;
      playSong(int'(last_idx));
    end

    $display("[TB] asynchronous reset mid-note");
    writeRam(0, 0, 3);
    last_idx = 2'd0;
    pulseStart;
    checkNote(0, 0, 4);
    chk("pre_reset_spk", 32'(speaker), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_spk", 32'(speaker), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_idx", 32'(note_idx), 0);
    chk("async_rst_done", 32'(done), 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Programmable square-wave melody player for the audio pin of the VGA/audio demo designs.
- Generalises the fixed-song tone engine in three ways:
  - note RAM is loaded at run time through a write port;
  - each note carries its own length multiplier;
  - start, stop and loop controls sequence playback, with busy and done status.
- Output `speaker` drives the speaker pin directly. The VGA logic uses `note_idx` and `done` for music-synced effects.

Parameters:
- ADDR_W, 5: note RAM address width. DEPTH = 2**ADDR_W entries.
- PERIOD_W, 18: width of the tone half-period field, in clocks.
- DUR_W, 25: width of the note duration counter. 4*NOTE_CYC-1 must fit in DUR_W bits.
- NOTE_CYC, 5035000: base note length in clocks (0.2 s at 25.175 MHz).
- GAP_CYC, 535000: silent tail at the end of every note, in clocks. Constraint: 0 < GAP_CYC < NOTE_CYC.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  note RAM write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  PERIOD_W+2  note entry: [PERIOD_W+1:PERIOD_W] = dur_code, [PERIOD_W-1:0] = period (0 = rest).
- start  in  1  single-cycle pulse; begin playback at index 0.
- stop  in  1  single-cycle pulse; abort playback.
- loop_en  in  1  1 = wrap from last_idx back to 0; 0 = one-shot.
- last_idx  in  ADDR_W  index of the final note of the song.
- speaker  out  1  square-wave audio.
- busy  out  1  high while playing.
- note_idx  out  ADDR_W  index of the note currently playing.
- done  out  1  single-cycle pulse at the end of a one-shot song.
- wr_err  out  1  single-cycle pulse when a write is rejected.

Behaviour:
- Reset: speaker, busy, note_idx, done, wr_err, all counters and the FSM go to 0 / IDLE. RAM contents are not reset.
- FSM has two states, IDLE and PLAY. busy = (state == PLAY), registered.
- Writes:
  - Accepted only in IDLE: RAM[wr_addr] is written at the clock edge.
  - wr_en while busy: the write is ignored and wr_err = 1 on the next cycle.
- Start and stop:
  - start in IDLE or in PLAY: next cycle state = PLAY, note_idx = 0, dur_cnt = 0, tone_cnt = 0, speaker = 0. A start during PLAY restarts the song.
  - stop in any state: next cycle IDLE with speaker = 0 and no done pulse. Stop wins over a simultaneous start.
- Note timing:
  - len = (dur_code+1) * NOTE_CYC, using the entry at note_idx, read combinationally or latched at note entry.
  - dur_cnt counts 0..len-1.
  - Audible window: dur_cnt < len - GAP_CYC.
- Tone generation in the audible window with period != 0:
  - tone_cnt counts 0..period-1.
  - At tone_cnt == period-1: speaker toggles and tone_cnt returns to 0.
  - The first toggle therefore lands on dur_cnt == period.
- Silence:
  - On the edge into dur_cnt == len - GAP_CYC, speaker and tone_cnt are cleared to 0.
  - Rest notes (period == 0) hold speaker = 0 for the whole note.
- End of note (dur_cnt == len-1):
  - dur_cnt, tone_cnt and speaker are cleared.
  - If note_idx != last_idx: note_idx + 1.
  - Else, loop_en = 1: note_idx = 0.
  - Else, loop_en = 0: go to IDLE and pulse done = 1 for one cycle.
  - loop_en and last_idx are sampled only at this boundary.
- last_idx < note_idx at a boundary: note_idx increments and wraps modulo DEPTH until it equals last_idx. No special case.
- period = 1: speaker toggles every clock in the audible window.
- Asynchronous reset mid-note: all outputs drop to 0 immediately.

Test Plan:
All scenarios use NOTE_CYC = 20, GAP_CYC = 4, ADDR_W = 2 unless stated.
- Single note, RAM[0] = {0, 3}, last_idx = 0, loop_en = 0, start pulse:
  - busy = 1 from the next cycle;
  - speaker = 1 at dur_cnt 3–5, 9–11 and 15, else 0;
  - speaker = 0 from dur_cnt 16;
  - done pulses exactly once, 20 cycles after busy rises;
  - busy = 0 on the cycle after done.
- Length and rest: RAM[0] = {3, 2}, RAM[1] = {0, 0}, last_idx = 1:
  - note 0 lasts 80 cycles, audible for the first 76;
  - note 1 lasts 20 cycles with speaker = 0 throughout;
  - note_idx reads 0 then 1; total busy = 100 cycles.
- Loop: last_idx = 2, loop_en = 1:
  - note_idx sequences 0, 1, 2, 0, 1, … with no done pulse;
  - clearing loop_en mid-note 2 gives done after note 2 of that pass.
- Stop and restart:
  - stop at dur_cnt 7 of note 1 → idle next cycle, speaker 0, no done;
  - start and stop in the same cycle → stays IDLE;
  - start mid-song → note_idx = 0 next cycle.
- Write protection:
  - wr_en during PLAY → wr_err pulse, and the RAM entry is unchanged when played later;
  - wr_en in IDLE → no wr_err.
- Reset: assert rst_n = 0 while speaker = 1 mid-note → speaker, busy and note_idx read 0 immediately, without waiting for a clock edge.
